// File: rtl/cpu_step_if.sv
// ---------------------------------------------------------------------------
// cpu_step_if
// Signal bundle between the board-level controls and the CPU step clock
// generator.
//   key_n        raw step button, active-low, asynchronous to clkin
//   mode_manual  1 = manual single step, 0 = free-running auto clock
//   rate_div     auto half-period = 2**rate_div clkin cycles
//   clk_cpu      registered CPU clock for the Pipeline clockCPU input
//   cpu_edge     one clkin-cycle strobe when clk_cpu rises
//   key_db       debounced key level, active-low
//   step_count   number of clk_cpu rising edges, wraps at 16 bits
//   state        controller state code for the LEDs
// master: board / testbench side, slave: cpu_step_ctrl.
// ---------------------------------------------------------------------------
interface cpu_step_if;
    logic        key_n;
    logic        mode_manual;
    logic [3:0]  rate_div;
    logic        clk_cpu;
    logic        cpu_edge;
    logic        key_db;
    logic [15:0] step_count;
    logic [2:0]  state;

    modport master (
        output key_n, mode_manual, rate_div,
        input  clk_cpu, cpu_edge, key_db, step_count, state
    );

    modport slave (
        input  key_n, mode_manual, rate_div,
        output clk_cpu, cpu_edge, key_db, step_count, state
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_step_ctrl
// Generates the CPU clock for the Pipeline core from the board clock.
// Auto mode: free-running clock with half-period 2**rate_div clkin cycles.
// Manual mode: exactly one CPU clock pulse (MAN_HI_CYC cycles high) per
// debounced button press; holding the button never repeats the step.
// Ports:
//   clkin   board clock, all logic on the rising edge
//   reset   asynchronous, active-low
//   bus     cpu_step_if.slave (key_n, mode_manual, rate_div in;
//           clk_cpu, cpu_edge, key_db, step_count, state out)
// ---------------------------------------------------------------------------
module cpu_step_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned DEB_W      = 20,
    parameter int unsigned MAN_HI_CYC = 4
) (
    input  logic       clkin,
    input  logic       reset,
    cpu_step_if.slave  bus
);

    typedef enum logic [2:0] {
        MAN_IDLE     = 3'd0,
        MAN_HI       = 3'd1,
        MAN_WAIT_REL = 3'd2,
        AUTO_LO      = 3'd3,
        AUTO_HI      = 3'd4
    } state_e;

    localparam int unsigned       MAN_W    = (MAN_HI_CYC > 1) ? $clog2(MAN_HI_CYC) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 32'd1);
    localparam logic [MAN_W-1:0]  MAN_LAST = MAN_W'(MAN_HI_CYC - 32'd1);

    logic             key_meta_r;
    logic             key_sync_r;
    logic             mode_meta_r;
    logic             mode_sync_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             key_db_r;
    logic             key_db_dly_r;
    logic             press_s;

    state_e           state_r;
    state_e           state_nx_s;
    logic [14:0]      phase_cnt_r;
    logic [14:0]      phase_cnt_nx_s;
    logic [3:0]       phase_lim_r;
    logic [3:0]       phase_lim_nx_s;
    logic [14:0]      phase_last_s;
    logic             phase_end_s;
    logic [MAN_W-1:0] man_cnt_r;
    logic [MAN_W-1:0] man_cnt_nx_s;

    logic             hi_nx_s;
    logic             enter_hi_s;
    logic             clk_cpu_r;
    logic             cpu_edge_r;
    logic [15:0]      step_count_r;

    // Two-flop synchronizers for the asynchronous button and mode switch.
    // They reset to "released" and "manual" so nothing moves out of MAN_IDLE
    // before the real switch level has arrived.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            key_meta_r  <= 1'b1;
            key_sync_r  <= 1'b1;
            mode_meta_r <= 1'b1;
            mode_sync_r <= 1'b1;
        end else begin
            key_meta_r  <= bus.key_n;
            key_sync_r  <= key_meta_r;
            mode_meta_r <= bus.mode_manual;
            mode_sync_r <= mode_meta_r;
        end
    end

    // Debounce: key_db follows the synced key only after DEB_CYCLES
    // consecutive cycles of disagreement; any bounce restarts the count.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            deb_cnt_r    <= {DEB_W{1'b0}};
            key_db_r     <= 1'b1;
            key_db_dly_r <= 1'b1;
        end else begin
            key_db_dly_r <= key_db_r;
            if (key_sync_r != key_db_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    key_db_r  <= key_sync_r;
                    deb_cnt_r <= {DEB_W{1'b0}};
                end else begin
                    deb_cnt_r <= deb_cnt_r + DEB_W'(1'b1);
                end
            end else begin
                deb_cnt_r <= {DEB_W{1'b0}};
            end
        end
    end

    // Press is the debounced 1->0 transition, one cycle wide.
    assign press_s = key_db_dly_r & ~key_db_r;

    // Last count of the current auto phase: 2**phase_lim_r - 1.
    assign phase_last_s = ~(15'h7FFF << phase_lim_r);
    assign phase_end_s  = (phase_cnt_r == phase_last_s);

    // Next-state logic; rate_div is captured whenever a new auto phase starts.
    always_comb begin
        state_nx_s     = state_r;
        phase_cnt_nx_s = phase_cnt_r;
        phase_lim_nx_s = phase_lim_r;
        man_cnt_nx_s   = man_cnt_r;
        case (state_r)
            MAN_IDLE: begin
                if (!mode_sync_r) begin
                    state_nx_s     = AUTO_LO;
                    phase_cnt_nx_s = 15'd0;
                    phase_lim_nx_s = bus.rate_div;
                end else if (press_s) begin
                    state_nx_s   = MAN_HI;
                    man_cnt_nx_s = {MAN_W{1'b0}};
                end else begin
                    state_nx_s = MAN_IDLE;
                end
            end
            MAN_HI: begin
                // Mode switch is deliberately ignored so the pulse is never cut.
                if (man_cnt_r == MAN_LAST) begin
                    state_nx_s = MAN_WAIT_REL;
                end else begin
                    man_cnt_nx_s = man_cnt_r + MAN_W'(1'b1);
                end
            end
            MAN_WAIT_REL: begin
                if (key_db_r) begin
                    state_nx_s = MAN_IDLE;
                end else begin
                    state_nx_s = MAN_WAIT_REL;
                end
            end
            AUTO_LO: begin
                // Leaving auto is only allowed here, so a high phase is never shortened.
                if (phase_end_s) begin
                    phase_cnt_nx_s = 15'd0;
                    phase_lim_nx_s = bus.rate_div;
                    if (mode_sync_r) begin
                        state_nx_s = MAN_IDLE;
                    end else begin
                        state_nx_s = AUTO_HI;
                    end
                end else begin
                    phase_cnt_nx_s = phase_cnt_r + 15'd1;
                end
            end
            AUTO_HI: begin
                if (phase_end_s) begin
                    phase_cnt_nx_s = 15'd0;
                    phase_lim_nx_s = bus.rate_div;
                    state_nx_s     = AUTO_LO;
                end else begin
                    phase_cnt_nx_s = phase_cnt_r + 15'd1;
                end
            end
            default: begin
                state_nx_s     = MAN_IDLE;
                phase_cnt_nx_s = 15'd0;
                phase_lim_nx_s = 4'd0;
                man_cnt_nx_s   = {MAN_W{1'b0}};
            end
        endcase
    end

    // Decode the high phases of the next state for the registered outputs.
    always_comb begin
        hi_nx_s    = 1'b0;
        enter_hi_s = 1'b0;
        if ((state_nx_s == MAN_HI) || (state_nx_s == AUTO_HI)) begin
            hi_nx_s    = 1'b1;
            enter_hi_s = (state_nx_s != state_r);
        end else begin
            hi_nx_s    = 1'b0;
            enter_hi_s = 1'b0;
        end
    end

    // State and phase counters.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_r     <= MAN_IDLE;
            phase_cnt_r <= 15'd0;
            phase_lim_r <= 4'd0;
            man_cnt_r   <= {MAN_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            phase_cnt_r <= phase_cnt_nx_s;
            phase_lim_r <= phase_lim_nx_s;
            man_cnt_r   <= man_cnt_nx_s;
        end
    end

    // Registered CPU clock, edge strobe and step counter, all updated on the
    // same edge so cpu_edge and the count change together with clk_cpu rising.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            clk_cpu_r    <= 1'b0;
            cpu_edge_r   <= 1'b0;
            step_count_r <= 16'd0;
        end else begin
            clk_cpu_r    <= hi_nx_s;
            cpu_edge_r   <= enter_hi_s;
            step_count_r <= step_count_r + {15'd0, enter_hi_s};
        end
    end

    assign bus.clk_cpu    = clk_cpu_r;
    assign bus.cpu_edge   = cpu_edge_r;
    assign bus.key_db     = key_db_r;
    assign bus.step_count = step_count_r;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_step_ctrl
// Self-checking bench for cpu_step_ctrl with DEB_CYCLES=4, MAN_HI_CYC=4.
// A negedge monitor counts clk_cpu rising edges, cpu_edge pulses, strobes
// that disagree with the observed clk_cpu edges, and key_db falls; each
// scenario task compares those counts and the measured phase widths with
// values derived from the clocking rules.
// ---------------------------------------------------------------------------
module tb_cpu_step_ctrl;

    logic clkin = 1'b0;
    logic rst_n;

    cpu_step_if bus ();

    cpu_step_ctrl #(
        .DEB_CYCLES (4),
        .DEB_W      (20),
        .MAN_HI_CYC (4)
    ) u_dut (
        .clkin (clkin),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;

    int   rise_cnt = 0;
    int   edge_cnt = 0;
    int   edge_bad = 0;
    int   kdb_fall = 0;
    logic prev_clk = 1'b0;
    logic prev_kdb = 1'b1;

    logic [15:0] model_steps = 16'd0;

    // Edge monitor sampled mid-cycle.
    always @(negedge clkin) begin
        if (rst_n !== 1'b1) begin
            prev_clk <= 1'b0;
            prev_kdb <= 1'b1;
        end else begin
            if (bus.clk_cpu === 1'b1 && prev_clk === 1'b0) rise_cnt <= rise_cnt + 1;
            if (bus.cpu_edge !== (bus.clk_cpu & ~prev_clk)) edge_bad <= edge_bad + 1;
            if (bus.cpu_edge === 1'b1) edge_cnt <= edge_cnt + 1;
            if (bus.key_db === 1'b0 && prev_kdb === 1'b1) kdb_fall <= kdb_fall + 1;
            prev_clk <= bus.clk_cpu;
            prev_kdb <= bus.key_db;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic sync_mon();
        @(negedge clkin);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_n = 1'b1;
        bus.mode_manual = 1'b1;
        bus.rate_div = 4'd0;
        cyc(3);
        checks++; if (bus.clk_cpu !== 1'b0) begin errors++; $display("FAIL reset_clk_cpu got %b exp 0", bus.clk_cpu); end
        checks++; if (bus.cpu_edge !== 1'b0) begin errors++; $display("FAIL reset_cpu_edge got %b exp 0", bus.cpu_edge); end
        checks++; if (bus.key_db !== 1'b1) begin errors++; $display("FAIL reset_key_db got %b exp 1", bus.key_db); end
        checks++; if (bus.step_count !== 16'd0) begin errors++; $display("FAIL reset_step_count got %h exp 0000", bus.step_count); end
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
        rst_n = 1'b1;
        model_steps = 16'd0;
        cyc(5);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL post_reset_state got %0d exp 0", bus.state); end
        checks++; if (bus.clk_cpu !== 1'b0) begin errors++; $display("FAIL post_reset_clk got %b exp 0", bus.clk_cpu); end
    endtask

    task automatic test_manual_step();
        int r0, e0, b0, f0, hi;
        r0 = rise_cnt; e0 = edge_cnt; b0 = edge_bad; f0 = kdb_fall; hi = 0;
        for (int i = 0; i < 20; i++) begin
            bus.key_n = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc(1);
            if (bus.clk_cpu === 1'b1) hi++;
        end
        model_steps = model_steps + 16'd1;
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL man_state_held got %0d exp 2", bus.state); end
        sync_mon();
        checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL man_rises got %0d exp 1", rise_cnt - r0); end
        checks++; if (edge_cnt - e0 != 1) begin errors++; $display("FAIL man_cpu_edge got %0d exp 1", edge_cnt - e0); end
        checks++; if (edge_bad != b0) begin errors++; $display("FAIL man_edge_align got %0d exp %0d", edge_bad, b0); end
        checks++; if (kdb_fall - f0 != 1) begin errors++; $display("FAIL man_key_db_falls got %0d exp 1", kdb_fall - f0); end
        checks++; if (hi != 4) begin errors++; $display("FAIL man_pulse_width got %0d exp 4", hi); end
        checks++; if (bus.step_count !== model_steps) begin errors++; $display("FAIL man_step_count got %h exp %h", bus.step_count, model_steps); end
        cyc(20);
        sync_mon();
        checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL man_hold_no_repeat got %0d exp 1", rise_cnt - r0); end
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL man_hold_state got %0d exp 2", bus.state); end
        bus.key_n = 1'b1;
        cyc(12);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL man_release_state got %0d exp 0", bus.state); end
        checks++; if (bus.key_db !== 1'b1) begin errors++; $display("FAIL man_release_key_db got %b exp 1", bus.key_db); end
    endtask

    task automatic test_manual_random();
        int r0, b0, f0, hi, hold, rel;
        int n;
        n = 4;
        r0 = rise_cnt; b0 = edge_bad; f0 = kdb_fall; hi = 0;
        for (int k = 0; k < n; k++) begin
            hold = $urandom_range(14, 30);
            for (int i = 0; i < hold; i++) begin
                bus.key_n = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
                cyc(1);
                if (bus.clk_cpu === 1'b1) hi++;
            end
            model_steps = model_steps + 16'd1;
            rel = $urandom_range(14, 20);
            for (int i = 0; i < rel + 3; i++) begin
                bus.key_n = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
                cyc(1);
                if (bus.clk_cpu === 1'b1) hi++;
            end
        end
        sync_mon();
        checks++; if (rise_cnt - r0 != n) begin errors++; $display("FAIL rnd_rises got %0d exp %0d", rise_cnt - r0, n); end
        checks++; if (hi != 4 * n) begin errors++; $display("FAIL rnd_high_cycles got %0d exp %0d", hi, 4 * n); end
        checks++; if (kdb_fall - f0 != n) begin errors++; $display("FAIL rnd_key_db_falls got %0d exp %0d", kdb_fall - f0, n); end
        checks++; if (edge_bad != b0) begin errors++; $display("FAIL rnd_edge_align got %0d exp %0d", edge_bad, b0); end
        checks++; if (bus.step_count !== model_steps) begin errors++; $display("FAIL rnd_step_count got %h exp %h", bus.step_count, model_steps); end
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rnd_state got %0d exp 0", bus.state); end
    endtask

    task automatic test_auto_rates();
        int rates[5];
        int b0, guard, run, phases, r0;
        logic last;
        rates[0] = 0;
        rates[1] = 3;
        for (int i = 2; i < 5; i++) rates[i] = $urandom_range(0, 4);
        b0 = edge_bad;
        sync_mon();
        r0 = rise_cnt;
        bus.mode_manual = 1'b0;
        for (int j = 0; j < 5; j++) begin
            bus.rate_div = 4'(rates[j]);
            last = bus.clk_cpu;
            guard = 0;
            do begin
                cyc(1);
                guard++;
            end while (bus.clk_cpu === last && guard < 100);
            if (guard >= 100) begin
                checks++; errors++;
                $display("FAIL auto_wait_boundary rate %0d got no edge exp edge within 100", rates[j]);
            end
            last = bus.clk_cpu;
            run = 1;
            phases = 0;
            guard = 0;
            while (phases < 6 && guard < 400) begin
                cyc(1);
                guard++;
                if (bus.clk_cpu === last) begin
                    run++;
                end else begin
                    checks++;
                    if (run != (1 << rates[j])) begin
                        errors++;
                        $display("FAIL auto_phase_width rate %0d got %0d exp %0d", rates[j], run, 1 << rates[j]);
                    end
                    phases++;
                    run = 1;
                end
                last = bus.clk_cpu;
            end
            if (phases < 6) begin
                checks++; errors++;
                $display("FAIL auto_phase_timeout rate %0d got %0d phases exp 6", rates[j], phases);
            end
        end
        sync_mon();
        model_steps = model_steps + 16'(rise_cnt - r0);
        checks++; if (edge_bad != b0) begin errors++; $display("FAIL auto_edge_align got %0d exp %0d", edge_bad, b0); end
        checks++; if (bus.step_count !== model_steps) begin errors++; $display("FAIL auto_step_count got %h exp %h", bus.step_count, model_steps); end
    endtask

    task automatic test_auto_count();
        int r0, guard;
        rst_n = 1'b0;
        cyc(2);
        bus.mode_manual = 1'b0;
        bus.rate_div = 4'd3;
        rst_n = 1'b1;
        model_steps = 16'd0;
        sync_mon();
        r0 = rise_cnt;
        guard = 0;
        while (rise_cnt - r0 < 10 && guard < 400) begin
            sync_mon();
            guard++;
        end
        model_steps = model_steps + 16'd10;
        checks++; if (rise_cnt - r0 != 10) begin errors++; $display("FAIL cnt_rises got %0d exp 10", rise_cnt - r0); end
        checks++; if (bus.step_count !== model_steps) begin errors++; $display("FAIL cnt_step_count got %h exp %h", bus.step_count, model_steps); end
        checks++; if (bus.cpu_edge !== 1'b1) begin errors++; $display("FAIL cnt_cpu_edge got %b exp 1", bus.cpu_edge); end
    endtask

    task automatic test_mode_switch();
        int guard, hi, lo, r0;
        logic last;
        last = bus.clk_cpu;
        guard = 0;
        do begin
            last = bus.clk_cpu;
            cyc(1);
            guard++;
        end while (!(bus.clk_cpu === 1'b1 && last === 1'b0) && guard < 60);
        hi = 1;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            if (bus.clk_cpu === 1'b1) hi++;
        end
        bus.mode_manual = 1'b1;
        guard = 0;
        while (guard < 40) begin
            cyc(1);
            guard++;
            if (bus.clk_cpu === 1'b1) hi++;
            else break;
        end
        checks++; if (hi != 8) begin errors++; $display("FAIL sw_high_width got %0d exp 8", hi); end
        lo = 1;
        guard = 0;
        while (guard < 40) begin
            cyc(1);
            guard++;
            if (bus.clk_cpu === 1'b0 && bus.state === 3'd3) lo++;
            else break;
        end
        checks++; if (lo != 8) begin errors++; $display("FAIL sw_low_width got %0d exp 8", lo); end
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL sw_state got %0d exp 0", bus.state); end
        checks++; if (bus.clk_cpu !== 1'b0) begin errors++; $display("FAIL sw_clk_cpu got %b exp 0", bus.clk_cpu); end
        sync_mon();
        model_steps = model_steps + 16'd1;
        r0 = rise_cnt;
        cyc(20);
        sync_mon();
        checks++; if (rise_cnt != r0) begin errors++; $display("FAIL sw_no_more_rises got %0d exp %0d", rise_cnt, r0); end
        checks++; if (bus.step_count !== model_steps) begin errors++; $display("FAIL sw_step_count got %h exp %h", bus.step_count, model_steps); end
    endtask

    task automatic test_wrap();
        int r0, last_r, guard;
        cyc(1);
        force u_dut.step_count_r = 16'hFFFD;
        cyc(2);
        release u_dut.step_count_r;
        model_steps = 16'hFFFD;
        cyc(1);
        checks++; if (bus.step_count !== model_steps) begin errors++; $display("FAIL wrap_preload got %h exp %h", bus.step_count, model_steps); end
        bus.rate_div = 4'd0;
        bus.mode_manual = 1'b0;
        sync_mon();
        r0 = rise_cnt;
        last_r = rise_cnt;
        guard = 0;
        while (rise_cnt - r0 < 3 && guard < 40) begin
            sync_mon();
            guard++;
            if (rise_cnt != last_r) begin
                last_r = rise_cnt;
                model_steps = model_steps + 16'd1;
                checks++; if (bus.step_count !== model_steps) begin errors++; $display("FAIL wrap_step got %h exp %h", bus.step_count, model_steps); end
                checks++; if (bus.cpu_edge !== 1'b1) begin errors++; $display("FAIL wrap_cpu_edge got %b exp 1", bus.cpu_edge); end
            end
        end
        checks++; if (bus.step_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", bus.step_count); end
        bus.mode_manual = 1'b1;
        guard = 0;
        while (bus.state !== 3'd0 && guard < 20) begin
            cyc(1);
            guard++;
        end
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL wrap_back_to_manual got %0d exp 0", bus.state); end
    endtask

    task automatic test_async_reset();
        int guard;
        bus.key_n = 1'b0;
        guard = 0;
        while (bus.clk_cpu !== 1'b1 && guard < 30) begin
            cyc(1);
            guard++;
        end
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL ar_in_man_hi got %0d exp 1", bus.state); end
        cyc(1);
        #2;
        rst_n = 1'b0;
        #1;
        model_steps = 16'd0;
        checks++; if (bus.clk_cpu !== 1'b0) begin errors++; $display("FAIL ar_clk_cpu got %b exp 0", bus.clk_cpu); end
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL ar_state got %0d exp 0", bus.state); end
        checks++; if (bus.step_count !== model_steps) begin errors++; $display("FAIL ar_step_count got %h exp %h", bus.step_count, model_steps); end
        checks++; if (bus.cpu_edge !== 1'b0) begin errors++; $display("FAIL ar_cpu_edge got %b exp 0", bus.cpu_edge); end
        bus.key_n = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL ar_after_state got %0d exp 0", bus.state); end
        checks++; if (bus.key_db !== 1'b1) begin errors++; $display("FAIL ar_after_key_db got %b exp 1", bus.key_db); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.key_n = 1'b1;
        bus.mode_manual = 1'b1;
        bus.rate_div = 4'd0;
        test_reset();
        test_manual_step();
        test_manual_random();
        test_auto_rates();
        test_auto_count();
        test_mode_switch();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
